// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of the UART register port.
// Optional watchdog enabled with `UART_ARB_TIMEOUT_EN` (TIMEOUT cycles in BUSY without ack).
module uart_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic [1:0]  m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic [1:0]  s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_r;
  logic        grant_r;
  logic        last_r;
  logic        busy_s;
  logic        sel_m1_s;
  logic        gnt_stb_s;
  logic        to_s;
  logic        done_s;
  logic [31:0] rdata_s;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] cnt_r;
  logic        timeout_r;

  // Watchdog counter: held at zero while idle, counts BUSY cycles without ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r     <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      if (!busy_s) begin
        cnt_r <= 16'd0;
      end else if (!s_ack_i) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (to_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign to_s      = busy_s && (cnt_r == TIMEOUT_C) && !s_ack_i;
  assign timeout_o = timeout_r;
`else
  assign to_s      = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Decode the current owner and the completion condition of its transaction.
  always_comb begin
    busy_s    = (state_r == BUSY);
    sel_m1_s  = busy_s && grant_r;
    gnt_stb_s = grant_r ? m1_stb_i : m0_stb_i;
    done_s    = busy_s && (s_ack_i || to_s);
    if (to_s) begin
      rdata_s = 32'hDEAD_BEEF;
    end else begin
      rdata_s = s_dat_i;
    end
  end

  // Slave-side request mux; idle defaults to m0 fields with the strobe gated off.
  always_comb begin
    if (sel_m1_s) begin
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_dat_o = m1_dat_i;
    end else begin
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_dat_o = m0_dat_i;
    end
    s_stb_o = busy_s && gnt_stb_s && !to_s;
  end

  // Master-side response steering and grant vector.
  always_comb begin
    m0_ack_o = done_s && !grant_r;
    m1_ack_o = done_s && grant_r;
    m0_dat_o = 32'h0000_0000;
    m1_dat_o = 32'h0000_0000;
    gnt_o    = 2'b00;
    if (busy_s && grant_r) begin
      m1_dat_o = rdata_s;
      gnt_o    = 2'b10;
    end else if (busy_s) begin
      m0_dat_o = rdata_s;
      gnt_o    = 2'b01;
    end else begin
      gnt_o    = 2'b00;
    end
  end

  // Arbitration FSM: a tie goes to the master that was not served last.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_stb_i || m1_stb_i) begin
            state_r <= BUSY;
            grant_r <= (m0_stb_i && m1_stb_i) ? ~last_r : m1_stb_i;
          end
        end
        BUSY: begin
          if (done_s) begin
            last_r  <= grant_r;
            state_r <= IDLE;
          end else if (!gnt_stb_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
